lander_burn_scheduler: RTL and testbench

- Arbitrates fuel-burn requests between the pilot switches and a built-in autopilot.
- Drives the lunar lander datapath's per-step burn amount (decr_combust).
- Sequences the descent with a flight-phase state machine and detects landing or crash.
- Sits between the switch inputs and the lander datapath; reads back altitude, velocity and fuel from the datapath.

---
 rtl/lander_burn_scheduler_if.sv | 31 +++
 rtl/lander_burn_scheduler.sv | 145 ++++++++++++++
 tb/tb_lander_burn_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lander_burn_scheduler_if.sv
// Bus between the switch/datapath side and the lander burn scheduler.
// The master side drives tick, the pilot switches and the datapath readback.
// The slave side is the scheduler, which returns the burn command and the flight phase.
interface lander_burn_scheduler_if #(
   parameter int NBITS_COMBUST = 8,
   parameter int NBITS_VELOCID = 12,
   parameter int NBITS_ALTURA  = 12
);
   logic                     tick;
   logic [6:0]               pilot_burn;
   logic                     auto_en;
   logic [NBITS_ALTURA-1:0]  altura;
   logic [NBITS_VELOCID-1:0] velocidade;
   logic [NBITS_COMBUST-1:0] combustivel;
   logic [6:0]               burn_cmd;
   logic [1:0]               burn_src;
   logic [1:0]               state;
   logic                     landed;
   logic                     crashed;
   logic [7:0]               burn_count;

   modport master (
      output tick, pilot_burn, auto_en, altura, velocidade, combustivel,
      input  burn_cmd, burn_src, state, landed, crashed, burn_count
   );

   modport slave (
      input  tick, pilot_burn, auto_en, altura, velocidade, combustivel,
      output burn_cmd, burn_src, state, landed, crashed, burn_count
   );
endinterface

// File: rtl/lander_burn_scheduler.sv
// Lander burn scheduler: arbitrates pilot and autopilot burn requests, clamps
// them to the available fuel, and tracks the flight phase through touchdown.
// Optional build macro FUEL_RESERVE_EN: pilot burns may not dip below
// RESERVE_FUEL; autopilot burns still use all remaining fuel.
module lander_burn_scheduler #(
   parameter int NBITS_COMBUST = 8,
   parameter int NBITS_VELOCID = 12,
   parameter int NBITS_ALTURA  = 12,
   parameter int BRAKE_ALT     = 100,
   parameter int SAFE_VEL      = 15,
   parameter int BRAKE_BURN    = 10,
   parameter int HOLDOFF       = 3,
   parameter int RESERVE_FUEL  = 20
) (
   input logic clk_2,
   input logic reset,
   lander_burn_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      FLIGHT  = 2'b00,
      BRAKE   = 2'b01,
      LANDED  = 2'b10,
      CRASHED = 2'b11
   } phase_t;

   localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
`ifdef FUEL_RESERVE_EN
   localparam int PILOT_RESERVE = RESERVE_FUEL;
`else
   localparam int PILOT_RESERVE = 0;
`endif

   localparam logic signed [NBITS_VELOCID-1:0] NEG_SAFE_VEL = NBITS_VELOCID'(-SAFE_VEL);
   localparam logic [NBITS_ALTURA-1:0]  ALT_BRAKE    = NBITS_ALTURA'(BRAKE_ALT);
   localparam logic [NBITS_COMBUST-1:0] FUEL_RESERVE = NBITS_COMBUST'(PILOT_RESERVE);
   localparam logic [6:0]               AUTO_BURN    = 7'(BRAKE_BURN);
   localparam logic [HOLD_W-1:0]        HOLD_LOAD    = HOLD_W'(HOLDOFF);

   phase_t                   state_reg, state_next;
   logic [6:0]               burn_cmd_reg, burn_cmd_next;
   logic [1:0]               burn_src_reg, burn_src_next;
   logic [7:0]               burn_count_reg, burn_count_next;
   logic [HOLD_W-1:0]        holdoff_reg, holdoff_next;

   logic                     fast_descent;
   logic                     touchdown;
   logic                     brake_zone;
   logic                     terminal;
   logic [NBITS_COMBUST-1:0] pilot_limit;
   logic [NBITS_COMBUST-1:0] limit;
   logic [6:0]               request;
   logic [1:0]               request_src;
   logic [6:0]               clamped;

   // min(request, fuel limit) evaluated at a width that fits both operands
   function automatic logic [6:0] clamp_burn(input logic [6:0] req,
                                             input logic [NBITS_COMBUST-1:0] lim);
      logic [31:0] req_w;
      logic [31:0] lim_w;
      req_w = 32'(req);
      lim_w = 32'(lim);
      return (req_w <= lim_w) ? req : 7'(lim);
   endfunction

   assign fast_descent = $signed(bus.velocidade) < NEG_SAFE_VEL;
   assign touchdown    = (bus.altura == '0);
   assign brake_zone   = (bus.altura <= ALT_BRAKE);
   assign terminal     = (state_reg == LANDED) || (state_reg == CRASHED);
   assign pilot_limit  = (bus.combustivel > FUEL_RESERVE) ? bus.combustivel - FUEL_RESERVE : '0;

   // Registered phase, burn command and counters; everything moves only on tick
   always_ff @(posedge clk_2) begin
      if (!reset) begin
         state_reg      <= FLIGHT;
         burn_cmd_reg   <= '0;
         burn_src_reg   <= 2'b00;
         burn_count_reg <= '0;
         holdoff_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         burn_cmd_reg   <= burn_cmd_next;
         burn_src_reg   <= burn_src_next;
         burn_count_reg <= burn_count_next;
         holdoff_reg    <= holdoff_next;
      end
   end

   // Phase transitions and burn arbitration, both from the current registered phase
   always_comb begin
      state_next      = state_reg;
      burn_cmd_next   = burn_cmd_reg;
      burn_src_next   = burn_src_reg;
      burn_count_next = burn_count_reg;
      holdoff_next    = holdoff_reg;
      request         = '0;
      request_src     = 2'b00;
      limit           = bus.combustivel;
      clamped         = '0;

      if (bus.tick) begin
         // touchdown outranks every other transition; terminal phases never leave
         if (!terminal) begin
            if (touchdown) begin
               state_next = fast_descent ? CRASHED : LANDED;
            end else if (state_reg == FLIGHT) begin
               if (bus.auto_en && brake_zone && fast_descent) state_next = BRAKE;
            end else begin
               if (!bus.auto_en || !fast_descent) state_next = FLIGHT;
            end
         end

         // pilot always wins; autopilot waits out the holdoff after a pilot burn
         if (!terminal) begin
            if (bus.pilot_burn != '0) begin
               request      = bus.pilot_burn;
               request_src  = 2'b01;
               limit        = pilot_limit;
               holdoff_next = HOLD_LOAD;
            end else begin
               if ((state_reg == BRAKE) && (holdoff_reg == '0)) begin
                  request     = AUTO_BURN;
                  request_src = 2'b10;
               end
               if (holdoff_reg != '0) holdoff_next = holdoff_reg - 1'b1;
            end
         end

         clamped       = clamp_burn(request, limit);
         burn_cmd_next = clamped;
         burn_src_next = (clamped == '0) ? 2'b00 : request_src;
         if ((clamped != '0) && (burn_count_reg != 8'hFF)) begin
            burn_count_next = burn_count_reg + 8'd1;
         end
      end
   end

   assign bus.burn_cmd   = burn_cmd_reg;
   assign bus.burn_src   = burn_src_reg;
   assign bus.state      = state_reg;
   assign bus.landed     = (state_reg == LANDED);
   assign bus.crashed    = (state_reg == CRASHED);
   assign bus.burn_count = burn_count_reg;

endmodule

// File: tb/tb_lander_burn_scheduler.sv
// Testbench for lander_burn_scheduler: directed steps followed by random ticks,
// each checked against a behavioural model of the burn/phase rules.
module tb_lander_burn_scheduler;

   logic clk_2 = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // reference model state (phase: 0 flight, 1 brake, 2 landed, 3 crashed)
   int m_state = 0;
   int m_hold  = 0;
   int m_count = 0;
   int m_cmd   = 0;
   int m_src   = 0;

   lander_burn_scheduler_if bus ();

   lander_burn_scheduler dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk_2 = ~clk_2;

   task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".state"},      32'(bus.state),      32'(m_state));
      check_val({tag, ".burn_cmd"},   32'(bus.burn_cmd),   32'(m_cmd));
      check_val({tag, ".burn_src"},   32'(bus.burn_src),   32'(m_src));
      check_val({tag, ".burn_count"}, 32'(bus.burn_count), 32'(m_count));
      check_val({tag, ".landed"},     32'(bus.landed),     32'(m_state == 2));
      check_val({tag, ".crashed"},    32'(bus.crashed),    32'(m_state == 3));
   endtask

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_hold = 0; m_count = 0; m_cmd = 0; m_src = 0;
   endfunction

   // one datapath step of the flight rules, in plain integer arithmetic
   function automatic void model_tick(input int p, input int a, input int alt, input int vel, input int fuel);
      int old_state;
      int pilot_fuel;
      old_state  = m_state;
`ifdef FUEL_RESERVE_EN
      pilot_fuel = (fuel > 20) ? fuel - 20 : 0;
`else
      pilot_fuel = fuel;
`endif
      if (old_state >= 2) begin
         m_cmd = 0; m_src = 0;
      end else if (p != 0) begin
         m_cmd  = min_int(p, pilot_fuel);
         m_src  = (m_cmd != 0) ? 1 : 0;
         m_hold = 3;
      end else begin
         if (old_state == 1 && m_hold == 0) begin
            m_cmd = min_int(10, fuel);
            m_src = (m_cmd != 0) ? 2 : 0;
         end else begin
            m_cmd = 0; m_src = 0;
         end
         if (m_hold > 0) m_hold--;
      end
      if (m_cmd != 0 && m_count < 255) m_count++;
      if (old_state < 2) begin
         if (alt == 0)                                              m_state = (vel >= -15) ? 2 : 3;
         else if (old_state == 0 && a != 0 && alt <= 100 && vel < -15) m_state = 1;
         else if (old_state == 1 && (a == 0 || vel >= -15))         m_state = 0;
      end
   endfunction

   task automatic do_tick(input int p, input int a, input int alt, input int vel, input int fuel, input string tag);
      @(negedge clk_2);
      bus.pilot_burn  = 7'(p);
      bus.auto_en     = (a != 0);
      bus.altura      = 12'(alt);
      bus.velocidade  = 12'(vel);
      bus.combustivel = 8'(fuel);
      bus.tick        = 1'b1;
      model_tick(p, a, alt, vel, fuel);
      @(negedge clk_2);
      bus.tick = 1'b0;
      $display("tick %s: pilot=%0d auto=%0d alt=%0d vel=%0d fuel=%0d -> state=%0d cmd=%0d src=%0d count=%0d",
               tag, p, a, alt, vel, fuel, bus.state, bus.burn_cmd, bus.burn_src, bus.burn_count);
      check_all(tag);
   endtask

   task automatic do_reset(input int cycles, input logic tick_during);
      @(negedge clk_2);
      reset      = 1'b0;
      bus.tick   = tick_during;
      bus.pilot_burn = 7'd5;
      repeat (cycles) @(negedge clk_2);
      reset      = 1'b1;
      bus.tick   = 1'b0;
      bus.pilot_burn = '0;
      model_reset();
      $display("reset %0d cycles: state=%0d cmd=%0d src=%0d count=%0d",
               cycles, bus.state, bus.burn_cmd, bus.burn_src, bus.burn_count);
      check_all("reset");
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_2);
         bus.pilot_burn = 7'($urandom_range(1, 127));
         bus.auto_en    = ~bus.auto_en;
         @(negedge clk_2);
         $display("idle %s %0d: state=%0d cmd=%0d src=%0d count=%0d",
                  tag, i, bus.state, bus.burn_cmd, bus.burn_src, bus.burn_count);
         check_all(tag);
      end
   endtask

   initial begin
      bus.tick = 1'b0; bus.pilot_burn = '0; bus.auto_en = 1'b0;
      bus.altura = 12'd500; bus.velocidade = '0; bus.combustivel = 8'd120;

      // reset state
      do_reset(2, 1'b0);
      check_val("rst_state", 32'(bus.state), 32'd0);

      // enter BRAKE, then pilot priority and holdoff
      do_tick(0, 1, 80, -40, 120, "to_brake");
      check_val("brake_entry", 32'(bus.state), 32'd1);
      do_tick(5, 1, 80, -40, 120, "pilot5");
      check_val("pilot5_cmd", 32'(bus.burn_cmd), 32'd5);
      check_val("pilot5_src", 32'(bus.burn_src), 32'd1);
      for (int i = 0; i < 3; i++) begin
         do_tick(0, 1, 80, -40, 120, "holdoff");
         check_val("holdoff_cmd", 32'(bus.burn_cmd), 32'd0);
      end
      do_tick(0, 1, 80, -40, 120, "auto_resume");
      check_val("auto_cmd", 32'(bus.burn_cmd), 32'd10);
      check_val("auto_src", 32'(bus.burn_src), 32'd2);

      // fuel clamp
      do_tick(20, 1, 80, -40, 4, "clamp4");
      check_val("clamp4_cmd", 32'(bus.burn_cmd), 32'd4);
      do_tick(20, 1, 80, -40, 0, "clamp0");
      check_val("clamp0_src", 32'(bus.burn_src), 32'd0);

      // let the holdoff drain, then exit BRAKE on a safe velocity
      for (int i = 0; i < 3; i++) do_tick(0, 1, 80, -40, 120, "drain");
      do_tick(0, 1, 80, -15, 120, "brake_exit");
      check_val("exit_state", 32'(bus.state), 32'd0);

      // brake entry at the boundary altitude/velocity
      do_tick(0, 1, 100, -16, 120, "edge_entry");
      check_val("edge_state", 32'(bus.state), 32'd1);
      do_tick(0, 1, 100, -16, 120, "edge_burn");
      check_val("edge_cmd", 32'(bus.burn_cmd), 32'd10);

      // no-tick hold, then reset mid-operation from BRAKE with tick asserted
      idle_cycles(10, "hold");
      do_reset(2, 1'b1);

      // touchdown: soft landing then crash
      do_tick(0, 0, 0, -15, 120, "land");
      check_val("landed", 32'(bus.landed), 32'd1);
      do_tick(7, 1, 0, -15, 120, "landed_pilot");
      check_val("landed_cmd", 32'(bus.burn_cmd), 32'd0);
      do_reset(1, 1'b0);
      do_tick(0, 0, 0, -16, 120, "crash");
      check_val("crashed", 32'(bus.crashed), 32'd1);
      do_reset(1, 1'b0);

`ifdef FUEL_RESERVE_EN
      do_tick(10, 0, 50, -5, 25, "reserve");
      check_val("reserve_cmd", 32'(bus.burn_cmd), 32'd5);
`endif

      // random flight steps against the model
      for (int n = 0; n < 400; n++) begin
         int p, a, alt, vel, fuel;
         if (m_state >= 2 && $urandom_range(0, 3) == 0) begin
            do_reset(1, 1'b0);
         end
         p    = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 127));
         a    = ($urandom_range(0, 3) != 0) ? 1 : 0;
         alt  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 200));
         vel  = int'($urandom_range(0, 80)) - 60;
         fuel = int'($urandom_range(0, 150));
         do_tick(p, a, alt, vel, fuel, "rand");
         if ($urandom_range(0, 7) == 0) idle_cycles(1, "rand_hold");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
